// File: rtl/zigzag_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// zigzag_pingpong_ctrl
//
// Sequencing controller for the JPEG zigzag reorder stage. It sits between
// the FDCT output and the quantiser and drives an external 2-bank x 64-entry
// coefficient RAM. Each bank holds one 8x8 block. The controller writes a
// block into one bank in FDCT order while it reads the other bank back in
// zigzag order. It carries no coefficient data, only addresses, strobes and
// flags.
//
// Parameters
//   IN_COL_MAJOR : 1 = input arrives column-major, so the write address is
//                  the transposed count; 0 = raster input.
//   BANK_AW      : address width per bank; must be 6.
//
// Ports
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_in_valid     : upstream offers a coefficient
//   o_in_ready     : a bank is available for writing
//   o_wr_en        : RAM write strobe (i_in_valid & o_in_ready)
//   o_wr_bank      : bank being written
//   o_wr_addr      : raster address within the write bank
//   o_rd_en        : RAM read strobe; RAM data is valid the next cycle
//   o_rd_bank      : bank being read
//   o_rd_addr      : raster address of zigzag index rcnt
//   o_out_valid    : RAM output register holds a zigzag-ordered coefficient
//   i_out_ready    : downstream accepts the current coefficient
//   o_out_idx      : zigzag index of the current output
//   o_out_first    : current output is index 0
//   o_out_last     : current output is index 63
//   o_busy         : a bank is in use or an output is pending
// ----------------------------------------------------------------------------
module zigzag_pingpong_ctrl #(
    parameter int unsigned IN_COL_MAJOR = 0,
    parameter int unsigned BANK_AW      = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic               o_wr_en,
    output logic               o_wr_bank,
    output logic [BANK_AW-1:0] o_wr_addr,
    output logic               o_rd_en,
    output logic               o_rd_bank,
    output logic [BANK_AW-1:0] o_rd_addr,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [BANK_AW-1:0] o_out_idx,
    output logic               o_out_first,
    output logic               o_out_last,
    output logic               o_busy
);

    generate
        if (BANK_AW != 6) begin : g_bad_aw
            $error("zigzag_pingpong_ctrl: BANK_AW must be 6");
        end
    endgenerate

    typedef enum logic [1:0] {StEmpty, StFill, StFull, StDrain} bank_state_e;

    // Raster address for each zigzag index k.
    localparam logic [BANK_AW-1:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    bank_state_e        r_state [2];
    logic               r_wb;
    logic               r_rb;
    logic [BANK_AW-1:0] r_wcnt;
    logic [BANK_AW-1:0] r_rcnt;
    logic               r_out_valid;
    logic [BANK_AW-1:0] r_out_idx;

    logic               w_in_ready;
    logic               w_wr_en;
    logic               w_wr_last;
    logic               w_rd_avail;
    logic               w_issue;
    logic               w_rd_last;
    logic [BANK_AW-1:0] w_wr_addr;

    // in_ready depends on registered state only, never on i_out_ready.
    assign w_in_ready = (r_state[r_wb] == StEmpty) || (r_state[r_wb] == StFill);
    assign w_wr_en    = i_in_valid && w_in_ready;
    assign w_wr_last  = (r_wcnt == {BANK_AW{1'b1}});

    // A read may issue whenever the output register is free or being consumed;
    // the RAM output register holds its value while rd_en is low.
    assign w_rd_avail = (r_state[r_rb] == StFull) || (r_state[r_rb] == StDrain);
    assign w_issue    = w_rd_avail && (!r_out_valid || i_out_ready);
    assign w_rd_last  = (r_rcnt == {BANK_AW{1'b1}});

    generate
        if (IN_COL_MAJOR != 0) begin : g_col_major
            assign w_wr_addr = {r_wcnt[2:0], r_wcnt[5:3]};
        end else begin : g_raster
            assign w_wr_addr = r_wcnt;
        end
    endgenerate

    // Write and read never touch the same bank in one cycle: the write bank
    // is EMPTY/FILL while the read bank is FULL/DRAIN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state[0]  <= StEmpty;
            r_state[1]  <= StEmpty;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            if (w_wr_en) begin
                if (w_wr_last) begin
                    r_state[r_wb] <= StFull;
                    r_wb          <= ~r_wb;
                    r_wcnt        <= '0;
                end else begin
                    r_state[r_wb] <= StFill;
                    r_wcnt        <= r_wcnt + 1'b1;
                end
            end

            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= r_rcnt;
                if (w_rd_last) begin
                    r_state[r_rb] <= StEmpty;
                    r_rb          <= ~r_rb;
                    r_rcnt        <= '0;
                end else begin
                    r_state[r_rb] <= StDrain;
                    r_rcnt        <= r_rcnt + 1'b1;
                end
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_wr_en     = w_wr_en;
    assign o_wr_bank   = r_wb;
    assign o_wr_addr   = w_wr_addr;
    assign o_rd_en     = w_issue;
    assign o_rd_bank   = r_rb;
    assign o_rd_addr   = ZZ[r_rcnt];
    assign o_out_valid = r_out_valid;
    assign o_out_idx   = r_out_idx;
    assign o_out_first = r_out_valid && (r_out_idx == '0);
    assign o_out_last  = r_out_valid && (r_out_idx == {BANK_AW{1'b1}});
    assign o_busy      = (r_state[0] != StEmpty) || (r_state[1] != StEmpty) || r_out_valid;

endmodule

// File: tb/tb_zigzag_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// tb_zigzag_pingpong_ctrl
//
// Bench for zigzag_pingpong_ctrl. Two DUTs share stimulus: dut0 with raster
// input and dut1 with column-major input. A block-level model (a queue of
// banks holding complete blocks plus write/read counters) predicts every
// output on each falling edge. Directed checks pin the zigzag table, latency,
// bank alternation, backpressure and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_zigzag_pingpong_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    logic       in_ready0, wr_en0, wr_bank0, rd_en0, rd_bank0;
    logic       out_valid0, out_first0, out_last0, busy0;
    logic [5:0] wr_addr0, rd_addr0, out_idx0;
    logic       in_ready1, wr_en1, wr_bank1, rd_en1, rd_bank1;
    logic       out_valid1, out_first1, out_last1, busy1;
    logic [5:0] wr_addr1, rd_addr1, out_idx1;

    zigzag_pingpong_ctrl #(.IN_COL_MAJOR(0), .BANK_AW(6)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready0),
        .o_wr_en(wr_en0), .o_wr_bank(wr_bank0), .o_wr_addr(wr_addr0), .o_rd_en(rd_en0),
        .o_rd_bank(rd_bank0), .o_rd_addr(rd_addr0), .o_out_valid(out_valid0),
        .i_out_ready(out_ready), .o_out_idx(out_idx0), .o_out_first(out_first0),
        .o_out_last(out_last0), .o_busy(busy0)
    );

    zigzag_pingpong_ctrl #(.IN_COL_MAJOR(1), .BANK_AW(6)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready1),
        .o_wr_en(wr_en1), .o_wr_bank(wr_bank1), .o_wr_addr(wr_addr1), .o_rd_en(rd_en1),
        .o_rd_bank(rd_bank1), .o_rd_addr(rd_addr1), .o_out_valid(out_valid1),
        .i_out_ready(out_ready), .o_out_idx(out_idx1), .o_out_first(out_first1),
        .o_out_last(out_last1), .o_busy(busy1)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Zigzag order built by walking the anti-diagonals of the 8x8 block.
    int zz [64];
    initial begin : p_zz
        int k, lo, hi;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    end

    // Block-level model: m_q holds banks with a complete block not yet drained.
    bit m_wb = 1'b0;
    int m_wcnt = 0;
    int m_q [$];
    int m_rcnt = 0;
    bit m_ov = 1'b0;
    int m_idx = 0;

    // Monitors, cleared by reset.
    int acc_cnt = 0;
    int rd_cnt = 0;
    int hs_cnt = 0;
    int stall_cnt = 0;
    int acc64_cyc = -1;
    int first_ov_cyc = -1;
    int first_hs_cyc = -1;
    int last_hs_cyc = -1;
    int bank_log [$];
    int rd_log [$];
    int wa0_log [64];
    int wa1_log [64];

    always @(negedge clk) begin : p_check
        bit e_in_ready, e_wr_en, e_issue, e_busy;
        int front;
        cyc++;
        if (!rst_n) begin
            m_wb = 1'b0; m_wcnt = 0; m_q.delete(); m_rcnt = 0; m_ov = 1'b0; m_idx = 0;
            acc_cnt = 0; rd_cnt = 0; hs_cnt = 0; stall_cnt = 0;
            acc64_cyc = -1; first_ov_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
            bank_log.delete(); rd_log.delete();
        end
        e_in_ready = (m_q.size() < 2);
        e_wr_en    = in_valid && e_in_ready;
        e_issue    = (m_q.size() > 0) && (!m_ov || out_ready);
        e_busy     = (m_q.size() > 0) || (m_wcnt != 0) || m_ov;
        front      = (m_q.size() > 0) ? m_q[0] : 0;

        chk("in_ready", int'(in_ready0), int'(e_in_ready));
        chk("in_ready_cm", int'(in_ready1), int'(e_in_ready));
        chk("wr_en", int'(wr_en0), int'(e_wr_en));
        chk("wr_bank", int'(wr_bank0), int'(m_wb));
        chk("rd_en", int'(rd_en0), int'(e_issue));
        chk("rd_en_cm", int'(rd_en1), int'(e_issue));
        chk("out_valid", int'(out_valid0), int'(m_ov));
        chk("out_valid_cm", int'(out_valid1), int'(m_ov));
        chk("out_idx", int'(out_idx0), m_idx);
        chk("out_idx_cm", int'(out_idx1), m_idx);
        chk("out_first", int'(out_first0), int'(m_ov && m_idx == 0));
        chk("out_last", int'(out_last0), int'(m_ov && m_idx == 63));
        chk("busy", int'(busy0), int'(e_busy));
        if (e_wr_en) begin
            chk("wr_addr", int'(wr_addr0), m_wcnt);
            chk("wr_addr_cm", int'(wr_addr1), (m_wcnt % 8) * 8 + m_wcnt / 8);
        end
        if (e_issue) begin
            chk("rd_bank", int'(rd_bank0), front);
            chk("rd_addr", int'(rd_addr0), zz[m_rcnt]);
            chk("rd_addr_cm", int'(rd_addr1), zz[m_rcnt]);
        end

        if (rst_n) begin
            if (in_valid && !in_ready0) stall_cnt++;
            if (wr_en0) begin
                if (acc_cnt % 64 == 0) bank_log.push_back(int'(wr_bank0));
                if (acc_cnt < 64) begin
                    wa0_log[acc_cnt] = int'(wr_addr0);
                    wa1_log[acc_cnt] = int'(wr_addr1);
                end
                acc_cnt++;
                if (acc_cnt == 64) acc64_cyc = cyc;
            end
            if (rd_en0) begin
                if (rd_cnt < 64) rd_log.push_back(int'(rd_addr0));
                rd_cnt++;
            end
            if (out_valid0 && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid0 && out_ready) begin
                chk("hs_order", int'(out_idx0), hs_cnt % 64);
                if (hs_cnt == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_cnt++;
            end

            // Advance the model to the state after the coming rising edge.
            if (e_issue) begin
                m_idx = m_rcnt;
                m_ov  = 1'b1;
                if (m_rcnt == 63) begin
                    m_rcnt = 0;
                    void'(m_q.pop_front());
                end else begin
                    m_rcnt++;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (e_wr_en) begin
                if (m_wcnt == 63) begin
                    m_q.push_back(int'(m_wb));
                    m_wb   = !m_wb;
                    m_wcnt = 0;
                end else begin
                    m_wcnt++;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Offer inputs until n accepts since reset; pv/pr are percent chances.
    task automatic feed(input int n, input int pv, input int pr, input int budget);
        for (int i = 0; i < budget && acc_cnt < n; i++) begin
            in_valid  = ($urandom_range(99) < pv);
            out_ready = ($urandom_range(99) < pr);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("feed_count", acc_cnt, n);
    endtask

    task automatic wait_hs(input int n, input int pr, input int budget);
        for (int i = 0; i < budget && hs_cnt < n; i++) begin
            out_ready = ($urandom_range(99) < pr);
            @(posedge clk); #1;
        end
        chk("hs_count", hs_cnt, n);
    endtask

    initial begin : p_main
        int exp_head [10];
        int exp_tail [4];
        exp_head = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
        exp_tail = '{47, 55, 62, 63};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_out_idx", int'(out_idx0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_rd_en", int'(rd_en0), 0);
        chk("rst_wr_bank", int'(wr_bank0), 0);
        rst_n = 1'b1;

        // One raster block, downstream always ready.
        feed(64, 100, 100, 200);
        wait_hs(64, 100, 200);
        chk("t1_latency", first_ov_cyc - acc64_cyc, 2);
        chk("t1_bank", (bank_log.size() > 0) ? bank_log[0] : -1, 0);
        chk("t1_rd_log_size", rd_log.size(), 64);
        if (rd_log.size() == 64) begin
            for (int i = 0; i < 10; i++) begin
                chk("zz_head", rd_log[i], exp_head[i]);
                chk("zz_model_head", zz[i], exp_head[i]);
            end
            for (int i = 0; i < 4; i++) begin
                chk("zz_tail", rd_log[60 + i], exp_tail[i]);
                chk("zz_model_tail", zz[60 + i], exp_tail[i]);
            end
        end
        chk("t1_wa_0", wa0_log[0], 0);
        chk("t1_wa_63", wa0_log[63], 63);
        chk("cm_addr_1", wa1_log[1], 8);
        chk("cm_addr_8", wa1_log[8], 1);
        chk("cm_addr_63", wa1_log[63], 63);

        // Three back-to-back blocks with no bubbles on either side.
        do_reset();
        feed(192, 100, 100, 400);
        chk("t2_no_stall", stall_cnt, 0);
        wait_hs(192, 100, 300);
        chk("t2_continuous", last_hs_cyc - first_hs_cyc, 191);
        chk("t2_nblocks", bank_log.size(), 3);
        if (bank_log.size() == 3) begin
            chk("t2_bank0", bank_log[0], 0);
            chk("t2_bank1", bank_log[1], 1);
            chk("t2_bank2", bank_log[2], 0);
        end

        // Downstream stalled from reset: both banks fill, one read only.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t3_accepted", acc_cnt, 128);
        chk("t3_in_ready", int'(in_ready0), 0);
        chk("t3_rd_count", rd_cnt, 1);
        chk("t3_out_valid", int'(out_valid0), 1);
        chk("t3_out_idx", int'(out_idx0), 0);
        wait_hs(128, 100, 400);

        // Random input and output handshakes over two blocks.
        do_reset();
        feed(128, 70, 50, 3000);
        wait_hs(128, 50, 3000);

        // Reset mid-block discards the partial block.
        do_reset();
        feed(40, 100, 100, 100);
        chk("t5_pre_busy", int'(busy0), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_in_ready", int'(in_ready0), 1);
        chk("t5_busy", int'(busy0), 0);
        chk("t5_out_valid", int'(out_valid0), 0);
        chk("t5_rd_en", int'(rd_en0), 0);
        chk("t5_wr_bank", int'(wr_bank0), 0);
        chk("t5_wr_addr", int'(wr_addr0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        feed(64, 100, 100, 200);
        wait_hs(64, 100, 200);
        chk("t5_first_addr", wa0_log[0], 0);
        chk("t5_bank", (bank_log.size() > 0) ? bank_log[0] : -1, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_extra_out", hs_cnt, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zigzag_pingpong_ctrl.md
Name: zigzag_pingpong_ctrl

Overview:
- Sequencing controller for the zigzag reorder stage of the JPEG encoder, between the FDCT output and the quantiser.
- Accepts 64 coefficients per 8x8 block in FDCT output order and drives write/read control of an external 2-bank x 64-entry coefficient RAM.
- Reads back in JPEG zigzag order, with ping-pong overlap so one block fills while the previous one drains.
- Carries no coefficient data itself; addresses, enables and flags only.

Parameters:
- IN_COL_MAJOR, 0, 1: input arrives column-major and write address is {col,row} swapped; 0: raster (row-major), write address = input count.
- BANK_AW, 6, address width per bank. Fixed at 6; any other value is a static error.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a coefficient this cycle.
- in_ready  output  1  controller accepts a coefficient this cycle.
- wr_en  output  1  RAM write strobe, = in_valid & in_ready.
- wr_bank  output  1  bank being written.
- wr_addr  output  6  raster address within bank.
- rd_en  output  1  RAM read strobe; RAM data valid the next cycle.
- rd_bank  output  1  bank being read.
- rd_addr  output  6  raster address = ZZ[rcnt].
- out_valid  output  1  RAM output holds a zigzag-ordered coefficient.
- out_ready  input  1  downstream accepts.
- out_idx  output  6  zigzag index k of the current output.
- out_first  output  1  out_valid & out_idx==0.
- out_last  output  1  out_valid & out_idx==63.
- busy  output  1  any bank not EMPTY or out_valid=1.

Behaviour:
- Per-bank state: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY. Registers: wb, rb (bank pointers), wcnt, rcnt (6-bit).
- Reset (async assert, sync-released use): both banks EMPTY, wb=rb=0, wcnt=rcnt=0, out_valid=0, out_idx=0. All strobes 0. in_ready=1 after reset.

Write side:
- in_ready = state[wb] is EMPTY or FILL (registered state; no combinational path from out_ready).
- Handshake: wr_addr = wcnt, or {wcnt[2:0],wcnt[5:3]} if IN_COL_MAJOR. wcnt increments. EMPTY -> FILL on the first accept.
- Handshake at wcnt==63: state[wb] -> FULL, wb toggles, wcnt wraps to 0.
- Both banks FULL/DRAIN: in_ready=0, no stall counters, data held upstream.

Read side:
- Issue condition: state[rb] in {FULL,DRAIN} and (!out_valid | out_ready).
- On issue: rd_en=1, rd_addr=ZZ[rcnt], rcnt++. FULL -> DRAIN on the first issue.
- Issue at rcnt==63: state[rb] -> EMPTY, rb toggles, rcnt wraps.
- out_valid is registered: set on the cycle after an issue, cleared when out_ready & no issue. out_idx is a registered copy of the issued rcnt.
- The RAM output register holds its value when rd_en=0. Stalled out_valid therefore keeps the data stable; the controller relies on this.
- Throughput: 1 coefficient/cycle each side. First-output latency from the 64th input accept is 2 cycles (state update + RAM read).

ZZ table:
- Standard JPEG zigzag, 64x6 ROM.
- ZZ[0..9] = 0,1,8,16,9,2,3,10,17,24.
- ZZ[60..63] = 47,55,62,63.

Boundary cases:
- Bank freed on the final issue cycle: in_ready rises the next cycle. The first write to that bank then follows the final read, so there is no read/write collision.
- Simultaneous events: write and read always target different banks by construction. wb==rb with one bank FILL and the other EMPTY is the idle case.
- Drain of bank A runs concurrently with fill of bank B, no bubbles.
- out_ready held low indefinitely: rd_en=0, rcnt frozen, out_valid/out_idx stable.
- rst_n asserted mid-block: partial block discarded, all state returns to reset values immediately (asynchronous).

Test Plan:
- Reset then 64 raster inputs (IN_COL_MAJOR=0), out_ready=1 -> wr_addr 0..63 on bank 0. rd_addr sequence 0,1,8,16,9,2,... with last four 47,55,62,63. out_first at the first output, out_last at the 64th. First out_valid 2 cycles after the 64th accept.
- 3 back-to-back blocks, continuous in_valid/out_ready -> in_ready never drops. Banks alternate 0,1,0. Output continuous 1/cycle after the initial latency.
- out_ready=0 from reset, 128 inputs offered -> exactly 128 accepted, then in_ready=0 (both FULL). At most 1 rd_en issued. out_valid=1 with out_idx=0 held stable.
- Random out_ready toggling (50%) for 2 blocks -> out_idx increments only on out_valid&out_ready; 128 handshakes in order; no duplicated or skipped index.
- IN_COL_MAJOR=1, input count 1 -> wr_addr 8. Count 8 -> wr_addr 1. Count 63 -> 63.
- rst_n pulsed low after 40 inputs of block 0 -> outputs at reset values immediately. The next block writes from wr_addr 0 on bank 0. No output from the aborted block.
